nibble_entry_ctrl: RTL

Controller that sequences manual entry of an N-bit word from the Arty A7 push-buttons and hands the finished word to a downstream consumer over a valid/ready handshake. It owns input synchronisation, edge detection, button lockout, bit counting, an inactivity timeout and a clear button. It sits between the board buttons and any block that consumes a complete nibble, such as a display or an ALU operand latch.

---
 rtl/nibble_entry_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/nibble_entry_ctrl.sv
// rtl/nibble_entry_ctrl.sv - push-button N-bit word entry with lockout, timeout, clear and valid/ready output
module nibble_entry_ctrl #(
  parameter int N       = 4,
  parameter int LOCKOUT = 1_000_000,
  parameter int TIMEOUT = 100_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_zeroes,
  input  logic                   i_ones,
  input  logic                   i_clear,
  input  logic                   i_ready,
  output logic [N-1:0]           o_data,
  output logic                   o_valid,
  output logic [$clog2(N+1)-1:0] o_count,
  output logic [1:0]             o_state,
  output logic                   o_timeout_flag
);
  localparam int CW = $clog2(N+1);
  localparam int LW = $clog2(LOCKOUT+1);
  localparam int TW = $clog2(TIMEOUT+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTER = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  // Bit order in the conditioning pipeline: [0]=zeroes, [1]=ones, [2]=clear
  logic [2:0]    w_btn;
  logic [2:0]    r_meta, r_s1, r_s2, r_pulse;
  logic [N-1:0]  r_data;
  logic [CW-1:0] r_count;
  logic [1:0]    r_state;
  logic          r_valid, r_tflag;
  logic [LW-1:0] r_lock;
  logic [TW-1:0] r_inact;
  logic          w_clr, w_accept, w_bit, w_timeout;

  assign w_btn = {i_clear, i_ones, i_zeroes};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta  <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_pulse <= '0;
    end else begin
      r_meta  <= w_btn;
      r_s1    <= r_meta;
      r_s2    <= r_s1;
      r_pulse <= r_s1 & ~r_s2;
    end
  end

  // Clear outranks a bit edge, so a bit arriving with clear is dropped and does not start a lockout.
  assign w_clr     = r_pulse[2];
  assign w_accept  = (r_pulse[0] | r_pulse[1]) && (r_lock == '0) && (r_state != S_FULL) && !w_clr;
  assign w_bit     = ~r_pulse[0];
  assign w_timeout = (r_state == S_ENTER) && !w_accept && (r_inact == TW'(TIMEOUT-1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lock <= '0;
    end else if (w_accept) begin
      r_lock <= LW'(LOCKOUT);
    end else if (r_lock != '0) begin
      r_lock <= r_lock - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_tflag <= 1'b0;
      r_inact <= '0;
    end else begin
      r_tflag <= 1'b0;
      if (w_clr) begin
        r_state <= S_IDLE;
        r_data  <= '0;
        r_count <= '0;
        r_valid <= 1'b0;
        r_inact <= '0;
      end else if (w_accept) begin
        r_data  <= {r_data[N-2:0], w_bit};
        r_count <= r_count + 1'b1;
        r_inact <= '0;
        if (r_count == CW'(N-1)) begin
          r_state <= S_FULL;
          r_valid <= 1'b1;
        end else begin
          r_state <= S_ENTER;
        end
      end else if (w_timeout) begin
        r_state <= S_IDLE;
        r_data  <= '0;
        r_count <= '0;
        r_tflag <= 1'b1;
        r_inact <= '0;
      end else if ((r_state == S_FULL) && i_ready) begin
        r_state <= S_IDLE;
        r_data  <= '0;
        r_count <= '0;
        r_valid <= 1'b0;
      end else if (r_state == S_ENTER) begin
        r_inact <= r_inact + 1'b1;
      end
    end
  end

  assign o_data         = r_data;
  assign o_valid        = r_valid;
  assign o_count        = r_count;
  assign o_state        = r_state;
  assign o_timeout_flag = r_tflag;
endmodule
